// File: rtl/read_return_reorder_pkg.sv
// Shared types for the read return path: tag/data sizing, return-channel record, reorder FSM states.
package types_def;

    localparam int read_entries_log = 3;
    localparam int data_width       = 32;

    // Return channel record used by the bank return arbiter and the reorder block.
    typedef struct packed {
        logic [read_entries_log-1:0] index;
        logic [data_width-1:0]       data;
    } read_return_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } rr_state_t;

endpackage

// File: rtl/read_return_reorder_slots.sv
// Reorder slot store: per-tag valid bitmap plus data array, one write port (returns)
// and one read/clear port (head).
module read_return_slots #(
    parameter int INDEX_W = 3,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_hit,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic               rd_clr,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data
);
    localparam int DEPTH = 2 ** INDEX_W;

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  wr_sel;
    logic [DEPTH-1:0]  clr_sel;
    logic [DATA_W-1:0] mem [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi]  = wr_en  && (wr_index == INDEX_W'(gi));
            assign clr_sel[gi] = rd_clr && (rd_index == INDEX_W'(gi));
        end
    endgenerate

    // A write landing on the slot being cleared wins, so the new data is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= (valid_reg & ~clr_sel) | wr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    assign wr_hit   = valid_reg[wr_index];
    assign rd_valid = valid_reg[rd_index];
    assign rd_data  = mem[rd_index];

endmodule

// File: rtl/read_return_reorder.sv
// In-order read response delivery with outstanding-read tracking and stop_reading backpressure.
// Optional protocol checking on err_o is enabled by defining READ_RETURN_CHECK_EN.
module read_return_reorder
    import types_def::*;
#(
    parameter int INDEX_W = read_entries_log,
    parameter int DATA_W  = data_width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic               ret_valid,
    input  logic [INDEX_W-1:0] ret_index,
    input  logic [DATA_W-1:0]  ret_data,
    input  logic               rnic_busy,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic [INDEX_W-1:0] out_index_o,
    output logic               stop_reading_o,
    output logic               err_o
);
    localparam int DEPTH = 2 ** INDEX_W;
    localparam logic [INDEX_W:0] CNT_FULL = (INDEX_W+1)'(DEPTH - 1);
    localparam logic [INDEX_W:0] CNT_MAX  = (INDEX_W+1)'(DEPTH);

    logic [INDEX_W-1:0] head_reg;
    logic [INDEX_W:0]   cnt_reg, cnt_next;
    rr_state_t          state_reg, state_next;
    logic               out_valid_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic [INDEX_W-1:0] out_index_reg;

    logic               slot_valid;
    logic [DATA_W-1:0]  slot_data;
    logic               wr_hit;
    logic               stage_free, load, deliver;

    read_return_slots #(
        .INDEX_W (INDEX_W),
        .DATA_W  (DATA_W)
    ) u_slots (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (ret_valid),
        .wr_index (ret_index),
        .wr_data  (ret_data),
        .wr_hit   (wr_hit),
        .rd_index (head_reg),
        .rd_clr   (load),
        .rd_valid (slot_valid),
        .rd_data  (slot_data)
    );

    assign stage_free = !out_valid_reg || !rnic_busy;
    assign load       = slot_valid && stage_free;
    assign deliver    = out_valid_reg && !rnic_busy;

    always_comb begin
        cnt_next = cnt_reg;
        case ({issue_valid, deliver})
            2'b10:   cnt_next = cnt_reg + (INDEX_W+1)'(1);
            2'b01:   cnt_next = cnt_reg - (INDEX_W+1)'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_comb begin
        state_next = ST_ACTIVE;
        if (cnt_next == '0) begin
            state_next = ST_EMPTY;
        end else if (cnt_next >= CNT_FULL) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            cnt_reg       <= '0;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_index_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                head_reg      <= head_reg + INDEX_W'(1);
                out_valid_reg <= 1'b1;
                out_data_reg  <= slot_data;
                out_index_reg <= head_reg;
            end else if (deliver) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid_o    = out_valid_reg;
    assign out_data_o     = out_data_reg;
    assign out_index_o    = out_index_reg;
    assign stop_reading_o = (state_reg == ST_FULL);

`ifdef READ_RETURN_CHECK_EN
    logic err_reg;
    logic err_event;

    assign err_event = (ret_valid && (wr_hit || cnt_reg == '0))
                    || (issue_valid && cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (err_event) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    logic unused_wr_hit;
    assign unused_wr_hit = wr_hit;
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_read_return_reorder.sv
// Directed, table-driven bench for read_return_reorder plus hand sequences for reset and error checks.
module tb_read_return_reorder;
    import types_def::*;

    localparam int IW = read_entries_log;
    localparam int DW = data_width;

`ifdef READ_RETURN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic         issue;
        logic         rv;
        read_return_t ret;
        logic         busy;
        logic         ev;
        logic [IW-1:0] ei;
        logic [DW-1:0] ed;
        logic         es;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic          ret_valid = 1'b0;
    logic [IW-1:0] ret_index = '0;
    logic [DW-1:0] ret_data = '0;
    logic          rnic_busy = 1'b0;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [IW-1:0] out_index_o;
    logic          stop_reading_o;
    logic          err_o;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    read_return_reorder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .ret_valid      (ret_valid),
        .ret_index      (ret_index),
        .ret_data       (ret_data),
        .rnic_busy      (rnic_busy),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_index_o    (out_index_o),
        .stop_reading_o (stop_reading_o),
        .err_o          (err_o)
    );

    task automatic check(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic add(input logic issue, input logic rv, input logic [IW-1:0] ri,
                       input logic [DW-1:0] rd, input logic busy, input logic ev,
                       input logic [IW-1:0] ei, input logic [DW-1:0] ed, input logic es);
        vec_t v;
        v.issue = issue; v.rv = rv; v.ret.index = ri; v.ret.data = rd; v.busy = busy;
        v.ev = ev; v.ei = ei; v.ed = ed; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic step(input logic issue, input logic rv, input logic [IW-1:0] ri,
                        input logic [DW-1:0] rd, input logic busy);
        issue_valid = issue; ret_valid = rv; ret_index = ri; ret_data = rd; rnic_busy = busy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // In-order: tags 0,1,2
        repeat (3) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 32'hA0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 32'hA1, 0, 1, 0, 32'hA0, 0);
        add(0, 1, 2, 32'hA2, 0, 1, 1, 32'hA1, 0);
        add(0, 0, 0, 0, 0, 1, 2, 32'hA2, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Out-of-order: head is 3, issue tags 3..6, return 6,4,5,3
        repeat (4) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 6, 32'hB6, 0, 0, 0, 0, 0);
        add(0, 1, 4, 32'hB4, 0, 0, 0, 0, 0);
        add(0, 1, 5, 32'hB5, 0, 0, 0, 0, 0);
        add(0, 1, 3, 32'hB3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 3, 32'hB3, 0);
        add(0, 0, 0, 0, 0, 1, 4, 32'hB4, 0);
        add(0, 0, 0, 0, 0, 1, 5, 32'hB5, 0);
        add(0, 0, 0, 0, 0, 1, 6, 32'hB6, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Backpressure across the 7 -> 0 wrap
        repeat (2) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 7, 32'hC7, 0, 0, 0, 0, 0);
        add(0, 1, 0, 32'hC0, 1, 1, 7, 32'hC7, 0);
        repeat (5) add(0, 0, 0, 0, 1, 1, 7, 32'hC7, 0);
        add(0, 0, 0, 0, 0, 1, 0, 32'hC0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Full threshold and second wrap: head is 1, issue 7
        repeat (6) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'hD1, 0, 0, 0, 0, 1);
        add(0, 1, 2, 32'hD2, 0, 1, 1, 32'hD1, 1);
        add(0, 1, 3, 32'hD3, 0, 1, 2, 32'hD2, 0);
        add(0, 1, 4, 32'hD4, 0, 1, 3, 32'hD3, 0);
        add(0, 1, 5, 32'hD5, 0, 1, 4, 32'hD4, 0);
        add(0, 1, 6, 32'hD6, 0, 1, 5, 32'hD5, 0);
        add(0, 1, 7, 32'hD7, 0, 1, 6, 32'hD6, 0);
        add(0, 0, 0, 0, 0, 1, 7, 32'hD7, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #12;
        check("reset_valid", 0, 64'(out_valid_o), 64'(0));
        check("reset_stop", 0, 64'(stop_reading_o), 64'(0));
        check("reset_err", 0, 64'(err_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].issue, vecs[i].rv, vecs[i].ret.index, vecs[i].ret.data, vecs[i].busy);
            $display("vec %0d: issue=%0d ret=%0d/%0d/%0h busy=%0d -> valid=%0d idx=%0d data=%0h stop=%0d",
                     i, vecs[i].issue, vecs[i].rv, vecs[i].ret.index, vecs[i].ret.data, vecs[i].busy,
                     out_valid_o, out_index_o, out_data_o, stop_reading_o);
            check("out_valid", i, 64'(out_valid_o), 64'(vecs[i].ev));
            check("stop_reading", i, 64'(stop_reading_o), 64'(vecs[i].es));
            if (vecs[i].ev) begin
                check("out_index", i, 64'(out_index_o), 64'(vecs[i].ei));
                check("out_data", i, 64'(out_data_o), 64'(vecs[i].ed));
            end
        end
        check("err_clean_traffic", 0, 64'(err_o), 64'(0));

        // Reset mid-operation: 3 outstanding, tag 0 held by busy
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 32'hE0, 1);
        step(0, 0, 0, 0, 1);
        check("held_valid", 1, 64'(out_valid_o), 64'(1));
        check("held_data", 1, 64'(out_data_o), 64'(32'hE0));
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0d idx=%0d data=%0h stop=%0d err=%0d",
                 out_valid_o, out_index_o, out_data_o, stop_reading_o, err_o);
        check("arst_valid", 2, 64'(out_valid_o), 64'(0));
        check("arst_index", 2, 64'(out_index_o), 64'(0));
        check("arst_data", 2, 64'(out_data_o), 64'(0));
        check("arst_stop", 2, 64'(stop_reading_o), 64'(0));
        check("arst_err", 2, 64'(err_o), 64'(0));
        issue_valid = 0; ret_valid = 0; rnic_busy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 32'hF0, 0);
        check("fresh_not_yet", 3, 64'(out_valid_o), 64'(0));
        step(0, 0, 0, 0, 0);
        $display("after reset: valid=%0d idx=%0d data=%0h", out_valid_o, out_index_o, out_data_o);
        check("fresh_valid", 3, 64'(out_valid_o), 64'(1));
        check("fresh_index", 3, 64'(out_index_o), 64'(0));
        check("fresh_data", 3, 64'(out_data_o), 64'(32'hF0));
        step(0, 0, 0, 0, 0);

        // Duplicate return to tag 2 without delivery
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 1, 2, 32'h62, 0);
        check("err_after_first", 4, 64'(err_o), 64'(0));
        step(0, 1, 2, 32'h63, 0);
        step(0, 0, 0, 0, 0);
        $display("duplicate return: err=%0d", err_o);
        check("err_dup", 4, 64'(err_o), 64'(EXP_ERR));
        repeat (3) step(0, 0, 0, 0, 0);
        check("err_sticky", 4, 64'(err_o), 64'(EXP_ERR));
        check("dup_no_output", 4, 64'(out_valid_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 5, 64'(err_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/read_return_reorder.md
# read_return_reorder

Return-path companion to the request mapper: collects read data coming back from the bank schedulers, tagged with the read index the mapper issued, and hands it to the RNIC strictly in issue order. Tracks outstanding reads and drives the `stop_reading` backpressure that the mapper samples. Sits between the back-end return arbiter and the RNIC read-response port.

## Interface
Parameters:
- `INDEX_W`, default `read_entries_log`: width of the read tag. Depth is `DEPTH = 2**INDEX_W`.
- `DATA_W`, default `data_width`: read data width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `issue_valid`  in  1  one pulse per read the mapper dispatched (mapper `valid_out_o` qualified by read type).
- `ret_valid`  in  1  return beat valid, from the bank return arbiter.
- `ret_index`  in  INDEX_W  tag of the returning read.
- `ret_data`  in  DATA_W  returned data.
- `rnic_busy`  in  1  RNIC cannot accept a response this cycle.
- `out_valid_o`  out  1  response valid to RNIC.
- `out_data_o`  out  DATA_W  response data.
- `out_index_o`  out  INDEX_W  tag of the response, for debug and ordering checks.
- `stop_reading_o`  out  1  to the mapper / overflow stopper.
- `err_o`  out  1  sticky protocol error; see Configuration.

## Operation
- Slot array of `DEPTH` entries, each holding a valid bit and data. A return writes `ret_data` into slot `ret_index` and sets its valid bit.
- `head` pointer (INDEX_W bits) starts at 0 and wraps modulo DEPTH. It mirrors the mapper's read counter, so tags leave in the order they were issued.
- Output register stage: loads from slot `head` when that slot is valid and the stage is free. The stage is free when `!out_valid_o || !rnic_busy`. On load, the slot's valid bit is cleared and `head` increments.
- Delivery happens when `out_valid_o && !rnic_busy` at a clock edge.
- Outstanding counter `cnt` is INDEX_W+1 bits wide:
  - increments on `issue_valid`;
  - decrements on delivery;
  - both events in the same cycle leave it unchanged.
- FSM, registered:
  - `EMPTY` when `cnt == 0`.
  - `ACTIVE` when `0 < cnt < DEPTH-1`.
  - `FULL` when `cnt >= DEPTH-1`.
  - The next state is computed from `cnt_next` each cycle.
- `stop_reading_o` is 1 exactly in `FULL`. The DEPTH-1 threshold absorbs the mapper's one-cycle registered issue path, so `cnt` never exceeds DEPTH.
- Simultaneous return to slot `head` and load from slot `head` in the same cycle: the load sees the old valid bit, and the new data is loaded next cycle. There is no bypass.
- Returns to non-head slots are accepted in any order.
- Reset, whenever it asserts, clears everything, including mid-burst:
  - all valid bits, `head`, and `cnt`;
  - FSM to `EMPTY`;
  - `out_valid_o=0`, `out_data_o=0`, `out_index_o=0`, `stop_reading_o=0`, `err_o=0`.
  - Data still in flight is discarded.

## Timing
- Return at edge k, with slot at `head` and the output stage free: `out_valid_o` is 1 after edge k+1. Minimum latency is 2 edges.
- Sustained throughput is 1 response per cycle while in-order returns keep arriving and `rnic_busy=0`.
- While `rnic_busy=1` and `out_valid_o=1`, `out_data_o` and `out_index_o` hold stable.
- `stop_reading_o` changes on the edge at which `cnt` crosses the threshold. It has no combinational path from inputs.
- `issue_valid` at edge k is counted at edge k. The return may arrive at any later cycle.

## Configuration
- `READ_RETURN_CHECK_EN` defined: `err_o` sets and stays set until reset on any of:
  - a return to a slot whose valid bit is already 1;
  - a return when `cnt == 0`;
  - `issue_valid` while `cnt == DEPTH`.
  - The offending write is still performed, overwriting the slot.
- `READ_RETURN_CHECK_EN` undefined: checking logic is absent and `err_o` is tied to 0.

## Structure
- Shared package `types_def`:
  - `read_entries_log` and `data_width` constants;
  - new typedef `read_return_t` (packed `{index, data}`), used for the return channel by the arbiter as well.
- Sub-module `read_return_slots`: valid bitmap plus data array, with one write port (return) and one read/clear port (head). The top level holds `head`, `cnt`, the FSM and the output stage.

## Test plan
- In-order: issue tags 0,1,2; return tags 0,1,2 on consecutive cycles with `rnic_busy=0` -> responses at 2-edge latency, back to back, data matches, `out_index_o` = 0,1,2.
- Out-of-order: issue 4; return tags 3,1,2,0 -> nothing output until tag 0 arrives, then tags 0,1,2,3 on four consecutive cycles.
- Backpressure: hold `rnic_busy=1` for 5 cycles with a response valid -> output holds stable; on release the remaining responses drain in order with no loss.
- Full and wrap: with INDEX_W=3, issue 7 without returns -> `stop_reading_o=1` after the 7th issue; return and deliver all -> drops to 0. Repeat to wrap `head` past 7 -> order preserved.
- Reset mid-operation: 3 outstanding, one response held by `rnic_busy` -> assert `rst_n=0` asynchronously -> all outputs 0 immediately; after release the block behaves as fresh (tag 0 expected first).
- With `READ_RETURN_CHECK_EN`: return tag 2 twice without delivery -> `err_o=1` and stays 1 until reset. Without the macro the same stimulus gives `err_o=0`.
